placement_readout: RTL and testbench

Streams the final placement out of the position RAM once the placement core reports completion. It is the read-side counterpart of the core's position writes: it walks node indices 0..n_node-1, reads each packed (x, y) entry through the same RAM port signals, and presents them on a valid/ready output stream. Coordinates outside the grid are flagged. It sits beside the placement core and shares the position RAM port with it through a mux selected by `busy`.

---
 rtl/placement_readout.sv | 113 +++++++++++
 tb/tb_placement_readout.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/placement_readout.sv
// rtl/placement_readout.sv - streams the final (x,y) placement out of the position RAM
// Walks node indices 0..n_node-1 through the shared RAM read port and flags off-grid coordinates.
module placement_readout #(
   parameter int GRID_SIZE          = 4,
   parameter int MEM_POSITION_DEPTH = 7,
   parameter int MEM_POSITION_WIDTH = 5
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_start,
   input  logic [MEM_POSITION_DEPTH-1:0]   i_n_node,
   output logic                            o_rd_en_mem_position,
   output logic [MEM_POSITION_DEPTH-1:0]   o_addr_mem_position,
   input  logic [2*MEM_POSITION_WIDTH-1:0] i_rd_mem_position_data,
   output logic                            o_out_valid,
   input  logic                            i_out_ready,
   output logic [MEM_POSITION_DEPTH-1:0]   o_out_node,
   output logic [MEM_POSITION_WIDTH-1:0]   o_out_x,
   output logic [MEM_POSITION_WIDTH-1:0]   o_out_y,
   output logic                            o_out_last,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_coord_err
);

   localparam logic [MEM_POSITION_WIDTH-1:0] L_GRID = MEM_POSITION_WIDTH'(GRID_SIZE);
   localparam logic [MEM_POSITION_DEPTH-1:0] L_ONE  = MEM_POSITION_DEPTH'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_PRESENT = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [MEM_POSITION_DEPTH-1:0]   r_idx;
   logic [MEM_POSITION_DEPTH-1:0]   r_count;
   logic [MEM_POSITION_DEPTH-1:0]   r_out_node;
   logic [MEM_POSITION_WIDTH-1:0]   r_out_x;
   logic [MEM_POSITION_WIDTH-1:0]   r_out_y;
   logic                            r_out_last;
   logic                            r_coord_err;
   logic [MEM_POSITION_WIDTH-1:0]   w_x;
   logic [MEM_POSITION_WIDTH-1:0]   w_y;
   logic                            w_off_grid;

   assign w_x        = i_rd_mem_position_data[2*MEM_POSITION_WIDTH-1:MEM_POSITION_WIDTH];
   assign w_y        = i_rd_mem_position_data[MEM_POSITION_WIDTH-1:0];
   assign w_off_grid = (w_x >= L_GRID) || (w_y >= L_GRID);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (i_start) w_state_nxt = (i_n_node == '0) ? S_FINISH : S_ISSUE;
         S_ISSUE:   w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_PRESENT;
         S_PRESENT: if (i_out_ready) w_state_nxt = r_out_last ? S_FINISH : S_ISSUE;
         S_FINISH:  w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_count     <= '0;
         r_out_node  <= '0;
         r_out_x     <= '0;
         r_out_y     <= '0;
         r_out_last  <= 1'b0;
         r_coord_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (i_start && (i_n_node != '0)) begin
                  r_count     <= i_n_node;
                  r_idx       <= '0;
                  r_coord_err <= 1'b0;
               end
            end
            S_CAPTURE: begin
               r_out_x    <= w_x;
               r_out_y    <= w_y;
               r_out_node <= r_idx;
               r_out_last <= (r_idx == (r_count - L_ONE));
               if (w_off_grid) r_coord_err <= 1'b1;
            end
            // idx only moves on entry to ISSUE, so the address holds between reads
            S_PRESENT: begin
               if (i_out_ready && !r_out_last) r_idx <= r_idx + L_ONE;
            end
            default: ;
         endcase
      end
   end

   assign o_rd_en_mem_position = (r_state == S_ISSUE);
   assign o_addr_mem_position  = r_idx;
   assign o_out_valid          = (r_state == S_PRESENT);
   assign o_out_node           = r_out_node;
   assign o_out_x              = r_out_x;
   assign o_out_y              = r_out_y;
   assign o_out_last           = r_out_last;
   assign o_busy               = (r_state != S_IDLE);
   assign o_done               = (r_state == S_FINISH);
   assign o_coord_err          = r_coord_err;

endmodule

// File: tb/tb_placement_readout.sv
// tb/tb_placement_readout.sv - randomized and directed checks of placement_readout
// A cycle-stamped transaction model predicts every output each cycle.
module tb_placement_readout;

   localparam int G = 4;
   localparam int D = 7;
   localparam int W = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           out_ready = 1'b0;
   logic [D-1:0]   n_node = '0;
   logic           rd_en;
   logic [D-1:0]   addr;
   logic [2*W-1:0] rd_data;
   logic           out_valid;
   logic [D-1:0]   out_node;
   logic [W-1:0]   out_x;
   logic [W-1:0]   out_y;
   logic           out_last;
   logic           busy;
   logic           done;
   logic           coord_err;

   always #5 clk = ~clk;

   placement_readout #(
      .GRID_SIZE(G), .MEM_POSITION_DEPTH(D), .MEM_POSITION_WIDTH(W)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_n_node(n_node),
      .o_rd_en_mem_position(rd_en), .o_addr_mem_position(addr),
      .i_rd_mem_position_data(rd_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_node(out_node), .o_out_x(out_x), .o_out_y(out_y),
      .o_out_last(out_last), .o_busy(busy), .o_done(done), .o_coord_err(coord_err)
   );

   // registered-read RAM; junk on the bus whenever no read was issued
   logic [2*W-1:0] mem [0:(1<<D)-1];
   always @(posedge clk) rd_data <= rd_en ? mem[addr] : (2*W)'($urandom);

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic l, input int node, input int x, input int y);
      return {14'd0, l, node[6:0], x[4:0], y[4:0]};
   endfunction

   // model state: cycle stamps of the next expected events
   int             cyc = 0;
   bit             m_busy = 0;
   bit             m_err = 0;
   int             m_n = 0, m_beat = 0;
   int             m_issue_cyc = -1, m_valid_cyc = -1, m_done_cyc = -1;
   logic [D-1:0]   m_addr = '0;
   logic [2*W-1:0] snap [0:(1<<D)-1];

   // observations used by the directed literal checks
   int             start_cyc = -1, done_cyc_obs = -1, err_rise_cyc = -1;
   int             rd_cnt = 0, valid_cnt = 0;
   bit             done_seen = 0, prev_err = 0;
   int             hs_cyc[$];
   logic [31:0]    hs_word[$];

   function automatic bit off_grid(input logic [2*W-1:0] d);
      return (int'(d[2*W-1:W]) >= G) || (int'(d[W-1:0]) >= G);
   endfunction

   always @(negedge clk) begin : cmp
      bit e_present;
      bit busy_next;
      cyc++;
      if (rst) begin
         chk("rst_rd_en", rd_en, 0);   chk("rst_addr", addr, 0);
         chk("rst_valid", out_valid, 0); chk("rst_node", out_node, 0);
         chk("rst_x", out_x, 0);       chk("rst_y", out_y, 0);
         chk("rst_last", out_last, 0); chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);     chk("rst_err", coord_err, 0);
         m_busy = 0; m_err = 0; m_addr = '0;
         m_issue_cyc = -1; m_valid_cyc = -1; m_done_cyc = -1;
      end else begin
         if (cyc == m_valid_cyc) m_err = m_err | off_grid(snap[m_beat]);
         if (cyc == m_issue_cyc) m_addr = D'(m_beat);
         e_present = (m_valid_cyc >= 0) && (cyc >= m_valid_cyc);
         chk("busy", busy, m_busy);
         chk("done", done, cyc == m_done_cyc);
         chk("rd_en", rd_en, cyc == m_issue_cyc);
         chk("addr", addr, m_addr);
         chk("out_valid", out_valid, e_present);
         chk("coord_err", coord_err, m_err);
         if (e_present) begin
            chk("out_node", out_node, m_beat);
            chk("out_x", out_x, snap[m_beat][2*W-1:W]);
            chk("out_y", out_y, snap[m_beat][W-1:0]);
            chk("out_last", out_last, m_beat == m_n - 1);
         end
         if (rd_en) rd_cnt++;
         if (out_valid) valid_cnt++;
         if (done) begin done_seen = 1; done_cyc_obs = cyc; end
         if (coord_err && !prev_err) err_rise_cyc = cyc;
         if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            hs_word.push_back(pk(out_last, out_node, out_x, out_y));
         end
         if (e_present && out_ready) begin
            if (m_beat == m_n - 1) begin
               m_done_cyc  = cyc + 1;
               m_valid_cyc = -1;
            end else begin
               m_beat++;
               m_issue_cyc = cyc + 1;
               m_valid_cyc = cyc + 3;
            end
         end
         busy_next = m_busy;
         if (m_busy && cyc == m_done_cyc) busy_next = 0;
         if (!m_busy && start) begin
            busy_next = 1;
            start_cyc = cyc;
            if (n_node == '0) begin
               m_done_cyc = cyc + 1;
            end else begin
               for (int i = 0; i < (1 << D); i++) snap[i] = mem[i];
               m_n = int'(n_node);
               m_beat = 0;
               m_err = 0;
               m_issue_cyc = cyc + 1;
               m_valid_cyc = cyc + 3;
            end
         end
         m_busy = busy_next;
      end
      prev_err = coord_err;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs;
      hs_cyc.delete();
      hs_word.delete();
      rd_cnt = 0; valid_cnt = 0; done_seen = 0;
      err_rise_cyc = -1; done_cyc_obs = -1;
   endtask

   task automatic do_start(input int n);
      n_node = D'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (!done_seen && k < limit) begin tick(); k++; end
      chk("done_timeout", done_seen, 1);
   endtask

   task automatic wait_valid(input int node);
      int k = 0;
      while (!(out_valid && int'(out_node) == node) && k < 30) begin tick(); k++; end
      chk("valid_timeout", out_valid, 1);
   endtask

   task automatic load_base;
      mem[0] = {5'd1, 5'd2};
      mem[1] = {5'd3, 5'd0};
      mem[2] = {5'd0, 5'd3};
   endtask

   task automatic chk_base_beats(input string tag);
      chk({tag, "_beats"}, hs_word.size(), 3);
      if (hs_word.size() == 3) begin
         chk({tag, "_b0"}, hs_word[0], pk(0, 0, 1, 2));
         chk({tag, "_b1"}, hs_word[1], pk(0, 1, 3, 0));
         chk({tag, "_b2"}, hs_word[2], pk(1, 2, 0, 3));
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << D); i++) mem[i] = '0;
      load_base();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_err", coord_err, 0);

      // nominal three-entry readout
      clear_obs(); out_ready = 1'b1;
      do_start(3);
      wait_done(60); tick();
      chk_base_beats("t1");
      if (hs_cyc.size() == 3) begin
         chk("t1_latency", hs_cyc[2] - start_cyc, 9);
         chk("t1_done_gap", done_cyc_obs - hs_cyc[2], 1);
      end
      chk("t1_err", coord_err, 0);
      chk("t1_rd_cnt", rd_cnt, 3);

      // back-pressure on the first beat
      clear_obs(); out_ready = 1'b0;
      do_start(3);
      wait_valid(0);
      repeat (5) tick();
      out_ready = 1'b1;
      wait_done(60); tick();
      chk_base_beats("t2");
      if (hs_cyc.size() > 0) chk("t2_stall", hs_cyc[0] - start_cyc, 8);
      chk("t2_rd_cnt", rd_cnt, 3);
      chk("t2_valid_cnt", valid_cnt, 8);

      // empty readout
      clear_obs();
      do_start(0);
      wait_done(10); tick();
      chk("t3_done_gap", done_cyc_obs - start_cyc, 1);
      chk("t3_rd_cnt", rd_cnt, 0);
      chk("t3_valid_cnt", valid_cnt, 0);

      // off-grid entry 1 sets a sticky flag
      mem[1] = {5'd4, 5'd1};
      clear_obs();
      do_start(3);
      wait_done(60); tick(); tick();
      chk("t4_err_rise", err_rise_cyc - start_cyc, 6);
      chk("t4_err_sticky", coord_err, 1);
      load_base();
      clear_obs();
      do_start(3);
      chk("t4_err_clear", coord_err, 0);
      wait_done(60); tick();

      // asynchronous reset while presenting entry 1
      clear_obs();
      do_start(3);
      wait_valid(1);
      rst = 1'b1;
      #1;
      chk("t5_valid", out_valid, 0); chk("t5_busy", busy, 0);
      chk("t5_node", out_node, 0);   chk("t5_x", out_x, 0);
      chk("t5_last", out_last, 0);   chk("t5_addr", addr, 0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("t5_no_done", done_seen, 0);
      clear_obs();
      do_start(3);
      wait_done(60); tick();
      chk_base_beats("t5");

      // start pulses while busy are ignored
      clear_obs();
      do_start(3);
      n_node = 7'd5; start = 1'b1; tick(); start = 1'b0;
      wait_valid(0);
      n_node = 7'd1; start = 1'b1; tick(); start = 1'b0;
      wait_done(60); tick();
      chk_base_beats("t6");
      chk("t6_rd_cnt", rd_cnt, 3);

      // randomized readouts with random back-pressure and stray starts
      for (int it = 0; it < 40; it++) begin
         int k;
         for (int i = 0; i < 16; i++)
            mem[i] = {W'($urandom_range(0, 4)), W'($urandom_range(0, 4))};
         clear_obs();
         do_start($urandom_range(0, 8));
         k = 0;
         while (k < 400) begin
            tick();
            start = 1'b0;
            if (done_seen) break;
            out_ready = ($urandom % 3) != 0;
            if ($urandom % 8 == 0) begin start = 1'b1; n_node = D'($urandom); end
            k++;
         end
         chk("rnd_done", done_seen, 1);
         out_ready = 1'b1;
         tick();
      end

      // maximum count
      for (int i = 0; i < (1 << D); i++)
         mem[i] = {W'($urandom_range(0, 3)), W'($urandom_range(0, 3))};
      clear_obs(); out_ready = 1'b1;
      do_start(127);
      wait_done(500); tick();
      chk("max_beats", hs_word.size(), 127);
      chk("max_rd_cnt", rd_cnt, 127);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
